pwm_ramp_ctrl: RTL and testbench
================================

# pwm_ramp_ctrl

Soft-start and duty-ramp sequencer that drives the configuration inputs of `pwm_top`: `duty`, `FINAL_VALUE`, `dt_value`, and its `reset_n`. It mirrors the PWM period internally and updates all outputs only at period boundaries, so the PWM never sees a mid-period change. It ramps duty toward a target at a programmable step and rate. It also runs a controlled ramp-down on disable and latches a hard shutdown on fault.

## Interface
Parameters:
- R, 8, PWM resolution; duty is R+1 bits, full scale 2^R = 100 %.
- TIMER_BITS, 8, width of the prescaler value FINAL_VALUE.
- DT_WIDTH, 8, width of the dead-time value.
- RATE_BITS, 8, width of the ramp-rate divider.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = run and ramp to target, 0 = ramp down to off.
- fault  in  1  synchronous level; 1 = immediate shutdown.
- fault_clr  in  1  pulse; clears the latched fault.
- target_duty  in  R+1  requested duty.
- step  in  R  duty increment per ramp step.
- rate  in  RATE_BITS  number of periods per step, minus 1.
- final_value_in  in  TIMER_BITS  requested prescaler value.
- dt_value_in  in  DT_WIDTH  requested dead-time, in clocks.
- cfg_load  in  1  pulse; capture final_value_in and dt_value_in.
- duty  out  R+1  to pwm_top duty.
- FINAL_VALUE  out  TIMER_BITS  to pwm_top FINAL_VALUE.
- dt_value  out  DT_WIDTH  to pwm_top dt_value.
- pwm_reset_n  out  1  to pwm_top reset_n; 0 holds the PWM off.
- period_tick  out  1  one-cycle pulse at each PWM period boundary.
- busy  out  1  1 in RAMP and RAMPDN.
- at_target  out  1  1 in HOLD.
- fault_latched  out  1  1 in FAULT.

## Operation
- States: IDLE, RAMP, HOLD, RAMPDN, FAULT. Reset sets state IDLE. All outputs reset to 0, including pwm_reset_n.
- Period mirror:
  - Runs only when pwm_reset_n=1.
  - Prescaler p counts 0..FINAL_VALUE. On wrap, the R-bit counter c increments.
  - period_tick=1 in the cycle where p==FINAL_VALUE and c==2^R-1.
  - The period is (FINAL_VALUE+1)*2^R clocks.
  - p and c are cleared whenever pwm_reset_n=0.
- Target handling:
  - The effective target is min(target_duty, 2^R). It is forced to 0 in RAMPDN.
  - step=0 is treated as 1.
- Ramp step:
  - A step occurs on every (rate+1)th period_tick, counted by a divider cleared on each state entry.
  - Going up: duty ← min(duty+step, tgt). Going down: duty ← max(duty−step, tgt).
  - Compute in R+2 bits so the result never wraps.
- duty changes only on a period_tick edge. It is also forced to 0 on a fault.
- Transitions:
  - IDLE → RAMP when enable=1 and fault=0. On the same edge:
    - pwm_reset_n←1.
    - FINAL_VALUE←final_value_in and dt_value←dt_value_in.
    - duty stays 0.
  - RAMP → HOLD on the step edge where duty reaches tgt. If tgt==0, go to HOLD on the first step edge.
  - HOLD → RAMP when tgt≠duty, on the next cycle.
  - RAMP/HOLD → RAMPDN when enable=0.
  - RAMPDN → RAMP when enable=1.
  - RAMPDN → IDLE on the step edge where duty becomes 0, with pwm_reset_n←0 on the same edge. If duty is already 0, go to IDLE on the next period_tick.
  - Any state → FAULT when fault=1. On that edge duty←0 and pwm_reset_n←0. Fault has priority over all other conditions.
  - FAULT → IDLE on fault_clr with fault=0 and enable=0. Otherwise fault_clr is ignored.
- Configuration:
  - cfg_load in RAMP, HOLD or RAMPDN captures the inputs into shadow registers. FINAL_VALUE and dt_value take the shadow values on the next period_tick edge.
  - If several cfg_load pulses arrive before that tick, the last one wins.
  - cfg_load in IDLE or FAULT is ignored. Start-up uses the live inputs.

## Timing
- enable sampled high at edge k: pwm_reset_n=1 after edge k.
- First period_tick: (FINAL_VALUE+1)*2^R−1 cycles after edge k.
- First duty step: on the (rate+1)th period_tick.
- Outputs duty, FINAL_VALUE, dt_value and pwm_reset_n are registered. They change together on a period_tick edge, or on a fault edge.
- fault sampled at edge f: duty=0 and pwm_reset_n=0 after edge f.
- Asynchronous reset mid-ramp returns all outputs to 0 immediately.

## Test plan
- Reset, then hold 100 clocks with enable=0 → all outputs 0, no period_tick.
- Ramp up with final_value_in=2, dt_value_in=5, target=128, step=32, rate=0:
  - period_tick every 768 clocks.
  - duty steps 32, 64, 96, 128 on ticks 1–4.
  - at_target=1 after tick 4; dt_value=5 and FINAL_VALUE=2 throughout.
- Non-multiple ramp with target=100, step=32 → duty 32, 64, 96, 100, then HOLD.
- Retarget down and reconfigure from HOLD at 128:
  - Set target=64, rate=1, plus a cfg_load with dt_value_in=20.
  - dt_value becomes 20 on the next tick.
  - duty becomes 96, then 64, on every 2nd tick; then HOLD.
- Disable at duty 128 with step=64, enable=0:
  - duty becomes 64, then 0.
  - On the edge where duty reaches 0: pwm_reset_n=0 and state IDLE.
  - Re-asserting enable while duty=64 resumes RAMP.
- Fault at duty=64 with fault pulsed for 1 cycle:
  - Next edge: duty=0, pwm_reset_n=0, fault_latched=1.
  - fault_clr with enable=1 is ignored.
  - After enable=0, fault_clr returns the block to IDLE with fault_latched=0.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start / duty-ramp sequencer for pwm_top: mirrors the PWM period and
// changes duty, prescaler and dead-time only on period boundaries or on fault.
module pwm_ramp_ctrl #(
   parameter int R          = 8,
   parameter int TIMER_BITS = 8,
   parameter int DT_WIDTH   = 8,
   parameter int RATE_BITS  = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  fault,
   input  logic                  fault_clr,
   input  logic [R:0]            target_duty,
   input  logic [R-1:0]          step,
   input  logic [RATE_BITS-1:0]  rate,
   input  logic [TIMER_BITS-1:0] final_value_in,
   input  logic [DT_WIDTH-1:0]   dt_value_in,
   input  logic                  cfg_load,
   output logic [R:0]            duty,
   output logic [TIMER_BITS-1:0] FINAL_VALUE,
   output logic [DT_WIDTH-1:0]   dt_value,
   output logic                  pwm_reset_n,
   output logic                  period_tick,
   output logic                  busy,
   output logic                  at_target,
   output logic                  fault_latched
);

   typedef enum logic [2:0] {S_IDLE, S_RAMP, S_HOLD, S_RAMPDN, S_FAULT} state_t;

   localparam logic [R:0]   FULL_SCALE = {1'b1, {R{1'b0}}};
   localparam logic [R+1:0] ONE_W      = {{(R+1){1'b0}}, 1'b1};

   state_t                state_reg, state_next;
   logic [TIMER_BITS-1:0] p_reg;
   logic [R-1:0]          c_reg;
   logic [RATE_BITS-1:0]  div_reg;
   logic [R:0]            duty_reg;
   logic [TIMER_BITS-1:0] fv_reg, fv_shadow_reg;
   logic [DT_WIDTH-1:0]   dt_reg, dt_shadow_reg;
   logic                  run_reg, pend_reg;

   logic                  tick, step_edge, do_step, start, active;
   logic [R:0]            tgt, tgt_capped;
   logic [R+1:0]          duty_w, tgt_w, step_w, up_sum, dn_diff, stepped_w;

   assign tick       = run_reg && (p_reg == fv_reg) && (c_reg == '1);
   assign step_edge  = tick && (div_reg == rate);
   assign tgt_capped = (target_duty > FULL_SCALE) ? FULL_SCALE : target_duty;
   assign tgt        = (state_reg == S_RAMPDN) ? '0 : tgt_capped;
   assign duty_w     = {1'b0, duty_reg};
   assign tgt_w      = {1'b0, tgt};
   assign step_w     = (step == '0) ? ONE_W : {2'b00, step};
   assign up_sum     = duty_w + step_w;
   assign dn_diff    = duty_w - step_w;

   // Saturating move toward tgt; the extra bit keeps both directions from wrapping.
   always_comb begin
      stepped_w = tgt_w;
      if (duty_w < tgt_w) begin
         if (up_sum < tgt_w) stepped_w = up_sum;
      end else if (duty_w >= step_w && dn_diff > tgt_w) begin
         stepped_w = dn_diff;
      end
   end

   assign active  = (state_reg == S_RAMP) || (state_reg == S_HOLD) || (state_reg == S_RAMPDN);
   assign start   = (state_reg == S_IDLE) && (state_next == S_RAMP);
   assign do_step = step_edge && !fault &&
                    (((state_reg == S_RAMP) && enable) || ((state_reg == S_RAMPDN) && !enable));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= S_IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (fault) begin
         state_next = S_FAULT;
      end else begin
         case (state_reg)
            S_IDLE:   if (enable) state_next = S_RAMP;
            S_RAMP:   if (!enable) state_next = S_RAMPDN;
                      else if (step_edge && stepped_w == tgt_w) state_next = S_HOLD;
            S_HOLD:   if (!enable) state_next = S_RAMPDN;
                      else if (tgt != duty_reg) state_next = S_RAMP;
            S_RAMPDN: if (enable) state_next = S_RAMP;
                      else if ((tick && duty_reg == '0) || (step_edge && stepped_w == '0))
                         state_next = S_IDLE;
            S_FAULT:  if (fault_clr && !enable) state_next = S_IDLE;
            default:  state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy          = (state_reg == S_RAMP) || (state_reg == S_RAMPDN);
      at_target     = (state_reg == S_HOLD);
      fault_latched = (state_reg == S_FAULT);
   end

   // Period mirror of pwm_top: held cleared while the PWM itself is held in reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n || !run_reg) begin
         p_reg <= '0;
         c_reg <= '0;
      end else if (p_reg == fv_reg) begin
         p_reg <= '0;
         c_reg <= c_reg + 1'b1;
      end else begin
         p_reg <= p_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                     div_reg <= '0;
      else if (state_next != state_reg) div_reg <= '0;
      else if (tick)                    div_reg <= (div_reg == rate) ? '0 : div_reg + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         duty_reg <= '0;
         run_reg  <= 1'b0;
      end else if (fault) begin
         duty_reg <= '0;
         run_reg  <= 1'b0;
      end else begin
         if (do_step) duty_reg <= stepped_w[R:0];
         if (start)
            run_reg <= 1'b1;
         else if (state_reg == S_RAMPDN && state_next == S_IDLE)
            run_reg <= 1'b0;
      end
   end

   // Shadowed configuration: applied only at a period boundary so the PWM never sees a torn period.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fv_reg        <= '0;
         dt_reg        <= '0;
         fv_shadow_reg <= '0;
         dt_shadow_reg <= '0;
         pend_reg      <= 1'b0;
      end else if (start) begin
         fv_reg   <= final_value_in;
         dt_reg   <= dt_value_in;
         pend_reg <= 1'b0;
      end else if (active) begin
         if (tick && pend_reg) begin
            fv_reg <= fv_shadow_reg;
            dt_reg <= dt_shadow_reg;
         end
         if (cfg_load) begin
            fv_shadow_reg <= final_value_in;
            dt_shadow_reg <= dt_value_in;
            pend_reg      <= 1'b1;
         end else if (tick) begin
            pend_reg <= 1'b0;
         end
      end
   end

   assign duty        = duty_reg;
   assign FINAL_VALUE = fv_reg;
   assign dt_value    = dt_reg;
   assign pwm_reset_n = run_reg;
   assign period_tick = tick;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed scenarios plus randomized traffic, compared every
// cycle against a cycle-count/integer reference model of the sequencer.
module tb_pwm_ramp_ctrl;
   localparam int R = 8, TIMER_BITS = 8, DT_WIDTH = 8, RATE_BITS = 8;
   localparam int FULL = 2 ** R;
   localparam int M_IDLE = 0, M_RAMP = 1, M_HOLD = 2, M_RAMPDN = 3, M_FAULT = 4;

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  enable = 1'b0, fault = 1'b0, fault_clr = 1'b0, cfg_load = 1'b0;
   logic [R:0]            target_duty = '0;
   logic [R-1:0]          step = '0;
   logic [RATE_BITS-1:0]  rate = '0;
   logic [TIMER_BITS-1:0] final_value_in = '0;
   logic [DT_WIDTH-1:0]   dt_value_in = '0;
   logic [R:0]            duty;
   logic [TIMER_BITS-1:0] FINAL_VALUE;
   logic [DT_WIDTH-1:0]   dt_value;
   logic                  pwm_reset_n, period_tick, busy, at_target, fault_latched;

   int n_checks = 0, n_errors = 0;
   bit check_en = 1'b0;
   int cyc = 0, n_ticks = 0, last_tick_cyc = -1, tick_interval = 0, prev_duty = 0;

   // Reference model state
   int m_state = 0, m_duty = 0, m_fv = 0, m_dt = 0, m_run = 0, m_cnt = 0, m_ticks = 0;
   int m_sh_fv = 0, m_sh_dt = 0, m_pend = 0;
   int t_tgt, t_st, t_tk, t_sedge, t_stepped, t_nxt, t_nduty, t_nrun;

   pwm_ramp_ctrl #(.R(R), .TIMER_BITS(TIMER_BITS), .DT_WIDTH(DT_WIDTH), .RATE_BITS(RATE_BITS)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .fault(fault), .fault_clr(fault_clr),
      .target_duty(target_duty), .step(step), .rate(rate), .final_value_in(final_value_in),
      .dt_value_in(dt_value_in), .cfg_load(cfg_load), .duty(duty), .FINAL_VALUE(FINAL_VALUE),
      .dt_value(dt_value), .pwm_reset_n(pwm_reset_n), .period_tick(period_tick), .busy(busy),
      .at_target(at_target), .fault_latched(fault_latched)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic finish_sim();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   endtask

   task automatic chk(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
         if (n_errors >= 40) finish_sim();
      end
   endtask

   // A period is (fv+1)*2^R clocks; the tick is its last clock.
   function automatic int m_tick();
      return (m_run != 0 && m_cnt == (m_fv + 1) * FULL - 1) ? 1 : 0;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_state = M_IDLE; m_duty = 0; m_fv = 0; m_dt = 0; m_run = 0; m_cnt = 0;
         m_ticks = 0; m_sh_fv = 0; m_sh_dt = 0; m_pend = 0;
      end else begin
         t_tgt = (m_state == M_RAMPDN) ? 0 : ((int'(target_duty) > FULL) ? FULL : int'(target_duty));
         t_st = (step == 0) ? 1 : int'(step);
         t_tk = m_tick();
         t_sedge = (t_tk != 0 && (m_ticks % (int'(rate) + 1)) == int'(rate)) ? 1 : 0;
         if (m_duty < t_tgt) t_stepped = (m_duty + t_st < t_tgt) ? m_duty + t_st : t_tgt;
         else                t_stepped = (m_duty - t_st > t_tgt) ? m_duty - t_st : t_tgt;
         t_nxt = m_state; t_nduty = m_duty; t_nrun = m_run;
         if (fault) begin
            t_nxt = M_FAULT; t_nduty = 0; t_nrun = 0;
         end else begin
            case (m_state)
               M_IDLE: if (enable) begin t_nxt = M_RAMP; t_nrun = 1; end
               M_RAMP: begin
                  if (!enable) t_nxt = M_RAMPDN;
                  else if (t_sedge != 0) begin
                     t_nduty = t_stepped;
                     if (t_stepped == t_tgt) t_nxt = M_HOLD;
                  end
               end
               M_HOLD: begin
                  if (!enable) t_nxt = M_RAMPDN;
                  else if (t_tgt != m_duty) t_nxt = M_RAMP;
               end
               M_RAMPDN: begin
                  if (enable) t_nxt = M_RAMP;
                  else if (m_duty == 0 && t_tk != 0) begin t_nxt = M_IDLE; t_nrun = 0; end
                  else if (t_sedge != 0) begin
                     t_nduty = t_stepped;
                     if (t_stepped == 0) begin t_nxt = M_IDLE; t_nrun = 0; end
                  end
               end
               default: if (fault_clr && !enable) t_nxt = M_IDLE;
            endcase
         end
         if (m_state == M_IDLE && t_nxt == M_RAMP) begin
            m_fv = int'(final_value_in); m_dt = int'(dt_value_in); m_pend = 0;
         end else if (m_state == M_RAMP || m_state == M_HOLD || m_state == M_RAMPDN) begin
            if (t_tk != 0 && m_pend != 0) begin m_fv = m_sh_fv; m_dt = m_sh_dt; end
            if (cfg_load) begin
               m_sh_fv = int'(final_value_in); m_sh_dt = int'(dt_value_in); m_pend = 1;
            end else if (t_tk != 0) m_pend = 0;
         end
         if (m_run != 0) m_cnt = (t_tk != 0) ? 0 : m_cnt + 1;
         else            m_cnt = 0;
         if (t_nxt != m_state) m_ticks = 0;
         else if (t_tk != 0)   m_ticks++;
         m_state = t_nxt; m_duty = t_nduty; m_run = t_nrun;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("duty", int'(duty), m_duty);
         chk("final_value", int'(FINAL_VALUE), m_fv);
         chk("dt_value", int'(dt_value), m_dt);
         chk("pwm_reset_n", int'(pwm_reset_n), m_run);
         chk("period_tick", int'(period_tick), m_tick());
         chk("busy", int'(busy), (m_state == M_RAMP || m_state == M_RAMPDN) ? 1 : 0);
         chk("at_target", int'(at_target), (m_state == M_HOLD) ? 1 : 0);
         chk("fault_latched", int'(fault_latched), (m_state == M_FAULT) ? 1 : 0);
         if (int'(duty) != prev_duty)
            $display("[%0t] duty %0d -> %0d", $time, prev_duty, int'(duty));
         prev_duty = int'(duty);
         if (period_tick) begin
            if (last_tick_cyc >= 0) tick_interval = cyc - last_tick_cyc;
            last_tick_cyc = cyc;
            n_ticks++;
         end
      end
   end

   function automatic int cond(input int sel, input int val);
      case (sel)
         0:       return (int'(duty) == val) ? 1 : 0;
         1:       return at_target ? 1 : 0;
         2:       return (!busy && !at_target && !fault_latched && !pwm_reset_n) ? 1 : 0;
         default: return (duty != 0) ? 1 : 0;
      endcase
   endfunction

   task automatic wait_cond(input int sel, input int val, input int budget, input string tag);
      int n = 0;
      while (cond(sel, val) == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, cond(sel, val), 1);
   endtask

   task automatic pulse(input int which);
      if (which == 0) cfg_load = 1'b1; else if (which == 1) fault = 1'b1; else fault_clr = 1'b1;
      @(negedge clk);
      cfg_load = 1'b0; fault = 1'b0; fault_clr = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_en = 1'b1;
      reset_n = 1'b1;
      $display("phase: idle after reset");
      repeat (100) @(negedge clk);
      chk("idle_ticks", n_ticks, 0);
      chk("idle_duty", int'(duty), 0);
      chk("idle_pwm_reset_n", int'(pwm_reset_n), 0);

      $display("phase: ramp up to 128");
      final_value_in = 8'd2; dt_value_in = 8'd5; target_duty = 9'd128; step = 8'd32; rate = '0;
      enable = 1'b1;
      wait_cond(1, 0, 5000, "ramp1_hold");
      chk("ramp1_duty", int'(duty), 128);
      chk("ramp1_fv", int'(FINAL_VALUE), 2);
      chk("ramp1_dt", int'(dt_value), 5);
      chk("tick_period", tick_interval, 768);
      final_value_in = 8'd7; dt_value_in = 8'd9;
      repeat (800) @(negedge clk);
      chk("no_cfg_fv", int'(FINAL_VALUE), 2);
      final_value_in = 8'd2; dt_value_in = 8'd5;

      $display("phase: ramp down, non-multiple ramp to 100");
      enable = 1'b0;
      wait_cond(2, 0, 5000, "rampdn1_idle");
      target_duty = 9'd100; enable = 1'b1;
      wait_cond(1, 0, 5000, "ramp100_hold");
      chk("ramp100_duty", int'(duty), 100);

      $display("phase: retarget down with reconfigure");
      target_duty = 9'd128;
      wait_cond(0, 128, 2000, "back128_duty");
      wait_cond(1, 0, 100, "back128_hold");
      target_duty = 9'd64; rate = 8'd1; dt_value_in = 8'd20;
      pulse(0);
      wait_cond(0, 64, 5000, "retgt_duty64");
      wait_cond(1, 0, 100, "retgt_hold");
      chk("retgt_dt", int'(dt_value), 20);
      rate = '0;

      $display("phase: disable with resume");
      target_duty = 9'd128; step = 8'd64;
      wait_cond(0, 128, 2000, "dis_up128");
      wait_cond(1, 0, 100, "dis_hold128");
      enable = 1'b0;
      wait_cond(0, 64, 2000, "dis_down64");
      enable = 1'b1;
      wait_cond(0, 128, 2000, "dis_resume128");
      wait_cond(1, 0, 100, "dis_resume_hold");
      enable = 1'b0;
      wait_cond(2, 0, 3000, "dis_idle");
      chk("dis_idle_duty", int'(duty), 0);

      $display("phase: fault");
      target_duty = 9'd64; enable = 1'b1;
      wait_cond(1, 0, 2000, "flt_hold64");
      pulse(1);
      chk("flt_duty", int'(duty), 0);
      chk("flt_pwm_reset_n", int'(pwm_reset_n), 0);
      chk("flt_latched", int'(fault_latched), 1);
      pulse(2);
      chk("flt_clr_ignored", int'(fault_latched), 1);
      enable = 1'b0;
      pulse(2);
      chk("flt_cleared", int'(fault_latched), 0);
      chk("flt_idle_busy", int'(busy), 0);

      $display("phase: random");
      rate = 8'($urandom_range(0, 1));
      for (int i = 0; i < 80; i++) begin
         enable = ($urandom_range(0, 9) < 8);
         target_duty = 9'($urandom_range(0, 300));
         step = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         final_value_in = 8'($urandom_range(0, 1));
         dt_value_in = 8'($urandom);
         $display("rand %0d: en=%0d tgt=%0d step=%0d rate=%0d", i, enable, target_duty, step, rate);
         if ($urandom_range(0, 2) == 0) pulse(0);
         if ($urandom_range(0, 19) == 0) pulse(1);
         if (fault_latched && $urandom_range(0, 1) == 0) begin
            enable = 1'b0;
            pulse(2);
         end
         repeat ($urandom_range(50, 600)) @(negedge clk);
      end

      $display("phase: asynchronous reset mid-ramp");
      enable = 1'b0;
      pulse(1);
      rate = '0;
      pulse(2);
      final_value_in = 8'd1; dt_value_in = 8'd33; target_duty = 9'd200; step = 8'd16;
      enable = 1'b1;
      wait_cond(3, 0, 2000, "arst_running");
      #2 reset_n = 1'b0;
      #1;
      chk("arst_duty", int'(duty), 0);
      chk("arst_fv", int'(FINAL_VALUE), 0);
      chk("arst_dt", int'(dt_value), 0);
      chk("arst_pwm_reset_n", int'(pwm_reset_n), 0);
      chk("arst_busy", int'(busy), 0);
      @(negedge clk);
      enable = 1'b0;
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      finish_sim();
   end
endmodule
